// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT front end.
package fft_pkg;

  localparam int unsigned BIT_WIDTH = 16;
  localparam int unsigned ADC_BITS  = 12;
  localparam int unsigned N         = 9;
  localparam int unsigned FFT_SIZE  = 2 ** N;
  localparam int unsigned CLK_HZ    = 48_000_000;
  localparam int unsigned FS        = 5000;

  // Read-side ownership of the read bank
  typedef enum logic {
    EMPTY,
    FULL
  } buf_state_t;

endpackage

// File: rtl/sample_frame_buf_if.sv
// ADC capture and frame read-out signals of the ping-pong frame buffer.
interface sample_frame_buf_if
  import fft_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = fft_pkg::BIT_WIDTH,
  parameter int unsigned ADC_BITS  = fft_pkg::ADC_BITS,
  parameter int unsigned N         = fft_pkg::N
) ();

  logic [ADC_BITS-1:0]  adc_data;
  logic                 adc_valid;
  logic                 sample_tick;
  logic                 frame_ready;
  logic                 frame_done;
  logic [N-1:0]         rd_addr;
  logic [BIT_WIDTH-1:0] rd_data;
  logic                 overrun;

  // Producer/consumer side (ADC + FFT loader)
  modport master (
    output adc_data, adc_valid, frame_done, rd_addr,
    input  sample_tick, frame_ready, rd_data, overrun
  );

  // Frame buffer side
  modport slave (
    input  adc_data, adc_valid, frame_done, rd_addr,
    output sample_tick, frame_ready, rd_data, overrun
  );

endinterface

// File: rtl/frame_ram.sv
// Simple dual-port RAM holding both frame banks; synchronous read for EBR inference.
module frame_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; array is never reset
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Registered read port; only the output register clears on reset
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sample_frame_buf.sv
// Ping-pong sample frame buffer: paces the ADC, converts samples to signed
// left-aligned fixed point and hands complete frames to the FFT loader.
module sample_frame_buf
  import fft_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = fft_pkg::BIT_WIDTH,
  parameter int unsigned ADC_BITS  = fft_pkg::ADC_BITS,
  parameter int unsigned N         = fft_pkg::N,
  parameter int unsigned FFT_SIZE  = fft_pkg::FFT_SIZE,
  parameter int unsigned CLK_HZ    = fft_pkg::CLK_HZ,
  parameter int unsigned FS        = fft_pkg::FS
) (
  input  logic           clk,
  input  logic           reset,
  sample_frame_buf_if.slave bus
);

  localparam int unsigned DIV   = CLK_HZ / FS;
  localparam int unsigned DIV_W = $clog2(DIV);
  localparam int unsigned SHIFT = BIT_WIDTH - ADC_BITS;

  logic [DIV_W-1:0]     div_q;
  logic                 tick_q;
  logic [N-1:0]         wr_ptr_q;
  logic                 wr_bank_q;
  logic                 overrun_q;
  logic [BIT_WIDTH-1:0] wr_data;
  logic                 fill_done;
  logic                 swap;
  logic                 drop;
  buf_state_t           state_q, state_d;

  // Sample-rate divider; tick is registered so it lands DIV cycles after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (div_q == DIV_W'(DIV - 1));
      div_q  <= (div_q == DIV_W'(DIV - 1)) ? '0 : div_q + DIV_W'(1);
    end
  end

  // Offset binary to two's complement: flip the MSB, then left-align
  always_comb begin
    wr_data = BIT_WIDTH'({~bus.adc_data[ADC_BITS-1], bus.adc_data[ADC_BITS-2:0]}) << SHIFT;
  end

  assign fill_done = bus.adc_valid && (wr_ptr_q == N'(FFT_SIZE - 1));

  // Write pointer and bank select
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      wr_bank_q <= 1'b0;
    end else begin
      if (bus.adc_valid) wr_ptr_q <= fill_done ? '0 : wr_ptr_q + N'(1);
      if (swap)          wr_bank_q <= ~wr_bank_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // FSM next state; a fill that lands while FULL either swaps (with frame_done) or is dropped
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (fill_done) state_d = FULL;
      FULL:  if (bus.frame_done && !fill_done) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // FSM outputs: bank swap and frame drop strobes
  always_comb begin
    swap = fill_done && ((state_q == EMPTY) || bus.frame_done);
    drop = fill_done && (state_q == FULL) && !bus.frame_done;
  end

  // Sticky overrun flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset)     overrun_q <= 1'b0;
    else if (drop) overrun_q <= 1'b1;
  end

  assign bus.sample_tick = tick_q;
  assign bus.frame_ready = (state_q == FULL);
  assign bus.overrun     = overrun_q;

  frame_ram #(
    .WIDTH (BIT_WIDTH),
    .DEPTH (2 * FFT_SIZE)
  ) u_frame_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (bus.adc_valid),
    .wr_addr ({wr_bank_q, wr_ptr_q}),
    .wr_data (wr_data),
    .rd_addr ({~wr_bank_q, bus.rd_addr}),
    .rd_data (bus.rd_data)
  );

endmodule

// File: tb/tb_sample_frame_buf.sv
// Directed bench for sample_frame_buf: reset/tick pacing, framing, ping-pong, overrun.
module tb_sample_frame_buf;
  import fft_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  sample_frame_buf_if bus ();

  sample_frame_buf u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers (no checking inside)
  task automatic push(input logic [11:0] d, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      bus.adc_valid = 1'b1;
      bus.adc_data  = d;
      @(posedge clk); #1;
    end
    bus.adc_valid = 1'b0;
  endtask

  task automatic push_ramp(input int first, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      bus.adc_valid = 1'b1;
      bus.adc_data  = 12'(first + i);
      @(posedge clk); #1;
    end
    bus.adc_valid = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a, output logic [15:0] v);
    bus.rd_addr = a;
    @(posedge clk); #1;
    v = bus.rd_data;
  endtask

  task automatic pulse_done();
    bus.frame_done = 1'b1;
    @(posedge clk); #1;
    bus.frame_done = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    int first_bad;
    int ticks;
    bus.adc_valid  = 1'b0;
    bus.adc_data   = '0;
    bus.frame_done = 1'b0;
    bus.rd_addr    = '0;
    do_reset(3);
    if (bus.sample_tick !== 1'b0) begin
      n_err++; $display("FAIL reset_tick: got %b want 0", bus.sample_tick);
    end
    n_chk++;
    if (bus.frame_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: got %b want 0", bus.frame_ready);
    end
    n_chk++;
    if (bus.overrun !== 1'b0) begin
      n_err++; $display("FAIL reset_overrun: got %b want 0", bus.overrun);
    end
    n_chk++;
    if (bus.rd_data !== 16'h0000) begin
      n_err++; $display("FAIL reset_rd_data: got %h want 0000", bus.rd_data);
    end
    n_chk++;
    // Tick must appear exactly in cycles 9600 and 19200 after release
    bad = 0; first_bad = -1; ticks = 0;
    for (int c = 1; c <= 19201; c++) begin
      @(posedge clk); #1;
      if (bus.sample_tick === 1'b1) ticks++;
      if (bus.sample_tick !== ((c == 9600) || (c == 19200))) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
    end
    if (bad != 0) begin
      n_err++; $display("FAIL tick_timing: %0d wrong cycles, first at %0d, want 0", bad, first_bad);
    end
    n_chk++;
    if (ticks != 2) begin
      n_err++; $display("FAIL tick_count: got %0d want 2", ticks);
    end
    n_chk++;
  endtask

  task automatic test_single_frame();
    logic [15:0] v;
    push_ramp(0, 511);
    if (bus.frame_ready !== 1'b0) begin
      n_err++; $display("FAIL single_ready_early: got %b want 0", bus.frame_ready);
    end
    n_chk++;
    push_ramp(511, 1);
    if (bus.frame_ready !== 1'b1) begin
      n_err++; $display("FAIL single_ready: got %b want 1", bus.frame_ready);
    end
    n_chk++;
    rd(9'd5, v);
    if (v !== 16'h8050) begin
      n_err++; $display("FAIL single_rd5: got %h want 8050", v);
    end
    n_chk++;
    rd(9'd0, v);
    if (v !== 16'h8000) begin
      n_err++; $display("FAIL single_rd0: got %h want 8000", v);
    end
    n_chk++;
    rd(9'd511, v);
    if (v !== 16'h9ff0) begin
      n_err++; $display("FAIL single_rd511: got %h want 9ff0", v);
    end
    n_chk++;
  endtask

  task automatic test_overrun();
    logic [15:0] v;
    push(12'h000, 512);
    if (bus.overrun !== 1'b1) begin
      n_err++; $display("FAIL ovr_flag: got %b want 1", bus.overrun);
    end
    n_chk++;
    if (bus.frame_ready !== 1'b1) begin
      n_err++; $display("FAIL ovr_ready: got %b want 1", bus.frame_ready);
    end
    n_chk++;
    rd(9'd5, v);
    if (v !== 16'h8050) begin
      n_err++; $display("FAIL ovr_held_rd5: got %h want 8050", v);
    end
    n_chk++;
    pulse_done();
    if (bus.frame_ready !== 1'b0) begin
      n_err++; $display("FAIL ovr_released: got %b want 0", bus.frame_ready);
    end
    n_chk++;
    push(12'hABC, 511);
    if (bus.frame_ready !== 1'b0) begin
      n_err++; $display("FAIL ovr_refill_early: got %b want 0", bus.frame_ready);
    end
    n_chk++;
    push(12'hABC, 1);
    if (bus.frame_ready !== 1'b1) begin
      n_err++; $display("FAIL ovr_refill_ready: got %b want 1", bus.frame_ready);
    end
    n_chk++;
    rd(9'd5, v);
    if (v !== 16'h2bc0) begin
      n_err++; $display("FAIL ovr_new_rd5: got %h want 2bc0", v);
    end
    n_chk++;
    if (bus.overrun !== 1'b1) begin
      n_err++; $display("FAIL ovr_sticky: got %b want 1", bus.overrun);
    end
    n_chk++;
  endtask

  task automatic test_ping_pong();
    logic [15:0] v;
    do_reset(1);
    push(12'h7FF, 512);
    if (bus.frame_ready !== 1'b1) begin
      n_err++; $display("FAIL pp_first_ready: got %b want 1", bus.frame_ready);
    end
    n_chk++;
    push(12'hFFF, 300);
    if (bus.frame_ready !== 1'b1) begin
      n_err++; $display("FAIL pp_held: got %b want 1", bus.frame_ready);
    end
    n_chk++;
    pulse_done();
    if (bus.frame_ready !== 1'b0) begin
      n_err++; $display("FAIL pp_fall: got %b want 0", bus.frame_ready);
    end
    n_chk++;
    push(12'hFFF, 211);
    if (bus.frame_ready !== 1'b0) begin
      n_err++; $display("FAIL pp_gap: got %b want 0", bus.frame_ready);
    end
    n_chk++;
    push(12'hFFF, 1);
    if (bus.frame_ready !== 1'b1) begin
      n_err++; $display("FAIL pp_rise: got %b want 1", bus.frame_ready);
    end
    n_chk++;
    rd(9'd0, v);
    if (v !== 16'h7ff0) begin
      n_err++; $display("FAIL pp_rd0: got %h want 7ff0", v);
    end
    n_chk++;
    rd(9'd299, v);
    if (v !== 16'h7ff0) begin
      n_err++; $display("FAIL pp_rd299: got %h want 7ff0", v);
    end
    n_chk++;
    rd(9'd511, v);
    if (v !== 16'h7ff0) begin
      n_err++; $display("FAIL pp_rd511: got %h want 7ff0", v);
    end
    n_chk++;
    if (bus.overrun !== 1'b0) begin
      n_err++; $display("FAIL pp_overrun: got %b want 0", bus.overrun);
    end
    n_chk++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    push(12'h123, 511);
    bus.adc_valid  = 1'b1;
    bus.adc_data   = 12'h123;
    bus.frame_done = 1'b1;
    @(posedge clk); #1;
    bus.adc_valid  = 1'b0;
    bus.frame_done = 1'b0;
    if (bus.frame_ready !== 1'b1) begin
      n_err++; $display("FAIL sim_ready: got %b want 1", bus.frame_ready);
    end
    n_chk++;
    if (bus.overrun !== 1'b0) begin
      n_err++; $display("FAIL sim_overrun: got %b want 0", bus.overrun);
    end
    n_chk++;
    rd(9'd7, v);
    if (v !== 16'h9230) begin
      n_err++; $display("FAIL sim_rd7: got %h want 9230", v);
    end
    n_chk++;
  endtask

  task automatic test_reset_mid_fill();
    logic [15:0] v;
    push(12'h456, 200);
    do_reset(1);
    if (bus.frame_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_ready: got %b want 0", bus.frame_ready);
    end
    n_chk++;
    push(12'h321, 511);
    if (bus.frame_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_early: got %b want 0", bus.frame_ready);
    end
    n_chk++;
    push(12'h321, 1);
    if (bus.frame_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_ready: got %b want 1", bus.frame_ready);
    end
    n_chk++;
    rd(9'd0, v);
    if (v !== 16'hb210) begin
      n_err++; $display("FAIL mid_rd0: got %h want b210", v);
    end
    n_chk++;
    rd(9'd100, v);
    if (v !== 16'hb210) begin
      n_err++; $display("FAIL mid_rd100: got %h want b210", v);
    end
    n_chk++;
    rd(9'd511, v);
    if (v !== 16'hb210) begin
      n_err++; $display("FAIL mid_rd511: got %h want b210", v);
    end
    n_chk++;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    test_reset();
    test_single_frame();
    test_overrun();
    test_ping_pong();
    test_back_to_back();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
